// File: rtl/zynq_hp_axi_mem_responder.sv
// AXI responder modelling PS DRAM behind HP0; serves INCR/FIXED bursts from an internal word array.
// Latency: first read beat 1 cycle after AR (1+read_delay_p with ZYNQ_HP_AXI_MEM_READ_DELAY_EN); writes 1 beat/cycle.
// Backpressure: one transaction in flight; R payload and B response held stable until rready/bready.
module zynq_hp_axi_mem_responder #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 32,
  parameter int C_S00_AXI_ID_WIDTH   = 6,
  parameter int mem_els_p            = 1024,
  parameter logic [C_S00_AXI_ADDR_WIDTH-1:0] base_addr_p = 32'h1000_0000,
  parameter int read_delay_p         = 8
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);
  localparam int dw_lp    = C_S00_AXI_DATA_WIDTH;
  localparam int aw_lp    = C_S00_AXI_ADDR_WIDTH;
  localparam int bytes_lp = dw_lp / 8;
  localparam int lsb_lp   = $clog2(bytes_lp);
  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int awx_lp   = aw_lp + 1;
  // One extra bit so the end of the window cannot wrap around the address space.
  localparam logic [awx_lp-1:0] base_x_lp = awx_lp'(base_addr_p);
  localparam logic [awx_lp-1:0] top_x_lp  = base_x_lp + awx_lp'(mem_els_p * bytes_lp);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
  localparam logic [2:0] ST_RWAIT = 3'd4;
  localparam int rd_cnt_w_lp = $clog2(read_delay_p + 1);
  logic [rd_cnt_w_lp-1:0] cnt_q, cnt_d;
`endif

  if (read_delay_p < 1) begin : g_bad_read_delay
    $error("read_delay_p must be at least 1");
  end

  logic [dw_lp-1:0] mem_q [mem_els_p];

  logic [2:0]                    state_q, state_d;
  logic                          prefer_w_q, prefer_w_d;
  logic [aw_lp-1:0]              addr_q, addr_d;
  logic [C_S00_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]                    len_q, len_d, beat_q, beat_d;
  logic [1:0]                    burst_q, burst_d;
  logic                          err_q, err_d;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [dw_lp-1:0]              rdata_q, rdata_d, rd_word;
  logic [1:0]                    rresp_q, rresp_d;
  logic                          mem_we, beat_err, ld_en, ld_err, ld_last;
  logic [aw_lp-1:0]              ld_addr, nxt_addr;

  function automatic logic addr_ok(input logic [aw_lp-1:0] a);
    logic [awx_lp-1:0] a_x;
    a_x = awx_lp'(a) & ~awx_lp'(bytes_lp - 1);
    return (a_x >= base_x_lp) && (a_x < top_x_lp);
  endfunction

  function automatic logic [idx_w_lp-1:0] idx_of(input logic [aw_lp-1:0] a);
    return idx_w_lp'((a - base_addr_p) >> lsb_lp);
  endfunction

  // Size must match the bus and only INCR/FIXED are served.
  function automatic logic hs_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'(lsb_lp)) || burst[1];
  endfunction

  assign s00_axi_wready = (state_q == ST_WDATA);
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bid    = id_q;
  assign s00_axi_bresp  = (bvalid_q && err_q) ? 2'b10 : 2'b00;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rid    = id_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rlast  = rlast_q;
  assign nxt_addr = (burst_q == 2'b00) ? addr_q : addr_q + aw_lp'(bytes_lp);

  // Next-state, arbitration and read-beat load selection.
  always_comb begin
    state_d = state_q; prefer_w_d = prefer_w_q; addr_d = addr_q; id_d = id_q;
    len_d = len_q; beat_d = beat_q; burst_d = burst_q; err_d = err_q;
    bvalid_d = bvalid_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rdata_d = rdata_q; rresp_d = rresp_q;
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
    cnt_d = cnt_q;
`endif
    s00_axi_awready = 1'b0; s00_axi_arready = 1'b0;
    mem_we = 1'b0; beat_err = 1'b0;
    ld_en = 1'b0; ld_addr = addr_q; ld_err = err_q; ld_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s00_axi_awready = ~areset & s00_axi_awvalid & (~s00_axi_arvalid | prefer_w_q);
        s00_axi_arready = ~areset & s00_axi_arvalid & (~s00_axi_awvalid | ~prefer_w_q);
        if (s00_axi_awready) begin
          addr_d = s00_axi_awaddr; id_d = s00_axi_awid; len_d = s00_axi_awlen;
          burst_d = s00_axi_awburst; beat_d = 8'd0;
          err_d = hs_err(s00_axi_awsize, s00_axi_awburst);
          state_d = ST_WDATA;
        end else if (s00_axi_arready) begin
          addr_d = s00_axi_araddr; id_d = s00_axi_arid; len_d = s00_axi_arlen;
          burst_d = s00_axi_arburst; beat_d = 8'd0;
          err_d = hs_err(s00_axi_arsize, s00_axi_arburst) | ~addr_ok(s00_axi_araddr);
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
          cnt_d = '0;
          state_d = ST_RWAIT;
`else
          ld_en = 1'b1; ld_addr = s00_axi_araddr; ld_err = err_d;
          ld_last = (s00_axi_arlen == 8'd0);
          state_d = ST_RDATA;
`endif
        end
      end
      ST_WDATA: begin
        if (s00_axi_wvalid) begin
          beat_err = err_q | ~addr_ok(addr_q) | (s00_axi_wlast != (beat_q == len_q));
          mem_we = ~beat_err;
          err_d = beat_err;
          addr_d = nxt_addr;
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            bvalid_d = 1'b1;
            state_d = ST_WRESP;
          end
        end
      end
      ST_WRESP: begin
        if (s00_axi_bready) begin
          bvalid_d = 1'b0; prefer_w_d = 1'b0; state_d = ST_IDLE;
        end
      end
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
      ST_RWAIT: begin
        if (cnt_q == rd_cnt_w_lp'(read_delay_p - 1)) begin
          ld_en = 1'b1; ld_addr = addr_q; ld_err = err_q; ld_last = (len_q == 8'd0);
          state_d = ST_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_RDATA: begin
        if (rvalid_q && s00_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0; rlast_d = 1'b0; rdata_d = '0; rresp_d = 2'b00;
            prefer_w_d = 1'b1; state_d = ST_IDLE;
          end else begin
            addr_d = nxt_addr; beat_d = beat_q + 8'd1;
            ld_err = err_q | ~addr_ok(nxt_addr); err_d = ld_err;
            ld_en = 1'b1; ld_addr = nxt_addr; ld_last = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_word = mem_q[idx_of(ld_addr)];
    if (ld_en) begin
      rvalid_d = 1'b1;
      rlast_d  = ld_last;
      rdata_d  = ld_err ? '0 : rd_word;
      rresp_d  = ld_err ? 2'b10 : 2'b00;
    end
  end

  // Control and output registers; an asserted reset aborts any transaction.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE; prefer_w_q <= 1'b1; addr_q <= '0; id_q <= '0;
      len_q <= '0; beat_q <= '0; burst_q <= '0; err_q <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0; rdata_q <= '0; rresp_q <= '0;
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d; prefer_w_q <= prefer_w_d; addr_q <= addr_d; id_q <= id_d;
      len_q <= len_d; beat_q <= beat_d; burst_q <= burst_d; err_q <= err_d;
      bvalid_q <= bvalid_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rdata_q <= rdata_d; rresp_q <= rresp_d;
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  // Byte-masked array write; contents deliberately survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (s00_axi_wstrb[b]) mem_q[idx_of(addr_q)][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_zynq_hp_axi_mem_responder.sv
// Directed bench for zynq_hp_axi_mem_responder: arbitration, bursts, strobes, errors, reset abort.
// Inputs driven at negedge (or #1 after posedge); outputs sampled away from the rising edge.
// Every wait on the DUT is bounded; a global watchdog ends the run if something stalls.
module tb_zynq_hp_axi_mem_responder;
  localparam logic [31:0] B = 32'h1000_0000;
`ifdef ZYNQ_HP_AXI_MEM_READ_DELAY_EN
  localparam int RD_DLY = 8;
`else
  localparam int RD_DLY = 0;
`endif

  logic        clk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [5:0]  awid = '0, arid = '0, bid, rid;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  int n_cmp = 0, n_err = 0;

  zynq_hp_axi_mem_responder dut (
    .aclk(clk), .areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awid(awid), .s00_axi_awlen(awlen),
    .s00_axi_awsize(awsize), .s00_axi_awburst(awburst),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arid(arid), .s00_axi_arlen(arlen),
    .s00_axi_arsize(arsize), .s00_axi_arburst(arburst),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rid(rid), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bu);
    @(negedge clk);
    awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1; #1;
    for (int t = 0; t < 20 && !awready; t++) begin @(negedge clk); #1; end
    chk("awready", awready, 1);
    @(posedge clk); #1; awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    @(negedge clk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1; #1;
    for (int t = 0; t < 20 && !wready; t++) begin @(negedge clk); #1; end
    chk("wready", wready, 1);
    @(posedge clk); #1; wvalid = 0;
  endtask

  task automatic do_b(input logic [5:0] eid, input logic [1:0] eresp, input string tag);
    @(negedge clk);
    for (int t = 0; t < 20 && !bvalid; t++) @(negedge clk);
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bid"}, bid, eid);
    chk({tag, "_bresp"}, bresp, eresp);
    bready = 1; @(posedge clk); #1; bready = 0;
    chk({tag, "_bvalid_clr"}, bvalid, 0);
  endtask

  // AR handshake plus the exact first-beat latency check.
  task automatic do_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bu);
    @(negedge clk);
    araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1; #1;
    for (int t = 0; t < 20 && !arready; t++) begin @(negedge clk); #1; end
    chk("arready", arready, 1);
    chk("rvalid_before_ar", rvalid, 0);
    @(posedge clk); #1; arvalid = 0;
    repeat (RD_DLY) begin @(posedge clk); #1; end
    chk("rvalid_latency", rvalid, 1);
  endtask

  task automatic do_r(input logic [31:0] d, input logic [5:0] id, input logic [1:0] resp,
                      input logic l, input string tag);
    @(negedge clk);
    for (int t = 0; t < 20 && !rvalid; t++) @(negedge clk);
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_rid"}, rid, id);
    chk({tag, "_rresp"}, rresp, resp);
    chk({tag, "_rlast"}, rlast, l);
    rready = 1; @(posedge clk); #1; rready = 0;
  endtask

  initial begin
    // Reset state, including readies suppressed while valids are presented in reset.
    repeat (3) @(negedge clk);
    awvalid = 1; arvalid = 1; #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    awvalid = 0; arvalid = 0;
    @(negedge clk); areset = 0;

    // Arbitration: simultaneous requests after reset -> AW first.
    @(negedge clk);
    awaddr = B + 32'h20; awid = 1; awlen = 0; awsize = 2; awburst = 1; awvalid = 1;
    araddr = B + 32'h20; arid = 2; arlen = 0; arsize = 2; arburst = 1; arvalid = 1; #1;
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    @(posedge clk); #1; awvalid = 0;
    chk("arb1_ar_blocked", arready, 0);
    do_w(32'h1111_1111, 4'hF, 1);
    @(negedge clk);
    chk("arb1_bvalid", bvalid, 1);
    chk("arb1_bid", bid, 1);
    bready = 1; @(posedge clk); #1; bready = 0;
    // Both requesting again right after the write: read now wins.
    awaddr = B + 32'h24; awid = 7; awvalid = 1; #1;
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    @(posedge clk); #1; arvalid = 0;
    do_r(32'h1111_1111, 2, 0, 1, "arb2_rd");
    chk("arb3_awready", awready, 1);
    chk("arb3_arready", arready, 0);
    @(posedge clk); #1; awvalid = 0;
    do_w(32'h2222_2222, 4'hF, 1);
    do_b(7, 0, "arb3");

    // Single-beat write and read-back.
    do_aw(B + 32'h10, 5, 0, 2, 1);
    do_w(32'hDEAD_BEEF, 4'hF, 1);
    do_b(5, 0, "single");
    do_ar(B + 32'h10, 3, 0, 2, 1);
    do_r(32'hDEAD_BEEF, 3, 0, 1, "single");

    // INCR burst write, read with stalls on beats 2 and 4.
    do_aw(B + 32'h40, 4, 3, 2, 1);
    for (int k = 0; k < 4; k++) do_w(32'(k + 1), 4'hF, k == 3);
    do_b(4, 0, "incr");
    do_ar(B + 32'h40, 6, 3, 2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("incr_rvalid", rvalid, 1);
      chk("incr_rdata", rdata, 32'(k + 1));
      chk("incr_rlast", rlast, (k == 3));
      if (k % 2 == 1) begin
        rready = 0;
        @(negedge clk);
        chk("incr_hold_rdata", rdata, 32'(k + 1));
        chk("incr_hold_rvalid", rvalid, 1);
      end
      rready = 1; @(posedge clk); #1; rready = 0;
    end
    chk("incr_done_rvalid", rvalid, 0);

    // Partial strobe merge.
    do_aw(B + 32'h80, 8, 0, 2, 1); do_w(32'hAAAA_AAAA, 4'hF, 1); do_b(8, 0, "strb_a");
    do_aw(B + 32'h80, 8, 0, 2, 1); do_w(32'h1234_5678, 4'b0011, 1); do_b(8, 0, "strb_b");
    do_ar(B + 32'h80, 8, 0, 2, 1);
    do_r(32'hAAAA_5678, 8, 0, 1, "strb");

    // Out-of-range read: two error beats.
    do_ar(B + 32'h1000, 9, 1, 2, 1);
    do_r(32'h0, 9, 2'b10, 0, "oob0");
    do_r(32'h0, 9, 2'b10, 1, "oob1");

    // Wrong size: SLVERR and no write.
    do_aw(B + 32'h10, 11, 0, 1, 1); do_w(32'h5555_5555, 4'hF, 1); do_b(11, 2'b10, "badsize");
    do_ar(B + 32'h10, 12, 0, 2, 1);
    do_r(32'hDEAD_BEEF, 12, 0, 1, "badsize_rd");

    // FIXED burst: last beat wins.
    do_aw(B + 32'hC0, 13, 2, 2, 0);
    do_w(32'd7, 4'hF, 0); do_w(32'd8, 4'hF, 0); do_w(32'd9, 4'hF, 1);
    do_b(13, 0, "fixed");
    do_ar(B + 32'hC0, 14, 0, 2, 1);
    do_r(32'd9, 14, 0, 1, "fixed");

    // Reset asserted while beat 2 of a 4-beat read is presented.
    do_ar(B + 32'h40, 10, 3, 2, 1);
    @(negedge clk);
    chk("rst_mid_beat1", rdata, 32'd1);
    rready = 1; @(posedge clk); #1; rready = 0;
    @(negedge clk);
    chk("rst_mid_beat2", rdata, 32'd2);
    areset = 1; #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rlast", rlast, 0);
    @(negedge clk); @(negedge clk); areset = 0;
    do_ar(B + 32'h44, 15, 0, 2, 1);
    do_r(32'd2, 15, 0, 1, "post_rst_a");
    do_ar(B + 32'h10, 16, 0, 2, 1);
    do_r(32'hDEAD_BEEF, 16, 0, 1, "post_rst_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
